adsr_envelope: RTL and testbench

//  Per-voice ADSR amplitude envelope. Sits between the NCO output and the audio_interface LDATA/RDATA inputs.
//  key_on (Nios PIO) gates the note. The stage scales each signed oscillator sample by a 16-bit envelope level

---
 rtl/adsr_envelope.sv | 130 +++++++++++++
 tb/tb_adsr_envelope.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope: steps a 16-bit level once per sample tick and
// scales each signed oscillator sample by it, removing clicks from hard note gating.
module adsr_envelope #(
    parameter int DATA_W = 16,
    parameter int ENV_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sample_tick,
    input  logic              key_on,
    input  logic [ENV_W-1:0]  attack_rate,
    input  logic [ENV_W-1:0]  decay_rate,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [ENV_W-1:0]  release_rate,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] sample_out,
    output logic [ENV_W-1:0]  env_level,
    output logic [2:0]        env_state,
    output logic              active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int PROD_W = DATA_W + ENV_W + 1;
    localparam logic [ENV_W-1:0] LEVEL_MAX = {ENV_W{1'b1}};
    localparam logic [ENV_W-1:0] RATE_ONE  = {{(ENV_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ENV_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                key_q;

    logic                key_rise;
    logic [ENV_W-1:0]    att_eff, dec_eff, rel_eff;
    logic [ENV_W:0]      att_sum, dec_diff, rel_diff;
    logic                att_full, dec_done, rel_done, gate_released;
    logic [ENV_W-1:0]    att_level;
    logic signed [PROD_W-1:0] prod;

    assign key_rise = key_on & ~key_q;

    // A zero rate is promoted to one so that no stage can stall forever.
    assign att_eff = (attack_rate  == '0) ? RATE_ONE : attack_rate;
    assign dec_eff = (decay_rate   == '0) ? RATE_ONE : decay_rate;
    assign rel_eff = (release_rate == '0) ? RATE_ONE : release_rate;

    // One extra bit on every step catches carry/borrow so the level saturates instead of wrapping.
    assign att_sum   = {1'b0, level_q} + {1'b0, att_eff};
    assign dec_diff  = {1'b0, level_q} - {1'b0, dec_eff};
    assign rel_diff  = {1'b0, level_q} - {1'b0, rel_eff};
    assign att_full  = (att_sum >= {1'b0, LEVEL_MAX});
    assign att_level = att_full ? LEVEL_MAX : att_sum[ENV_W-1:0];
    assign dec_done  = dec_diff[ENV_W] | (dec_diff[ENV_W-1:0] <= sustain_level);
    assign rel_done  = rel_diff[ENV_W] | (rel_diff[ENV_W-1:0] == '0);

    assign gate_released = ~key_on &
        ((state_q == S_ATTACK) | (state_q == S_DECAY) | (state_q == S_SUSTAIN));

    assign prod = $signed({{(ENV_W + 1){sample_in[DATA_W-1]}}, sample_in}) *
                  $signed({{DATA_W{1'b0}}, 1'b0, level_q});

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        sample_d = sample_q;

        if (sample_tick) begin
            sample_d = DATA_W'(prod >>> ENV_W);
        end

        if (key_rise) begin
            state_d = S_ATTACK;
            if (sample_tick) begin
                level_d = att_level;
                state_d = att_full ? S_DECAY : S_ATTACK;
            end
        end else if (sample_tick) begin
            if (gate_released || state_q == S_RELEASE) begin
                level_d = rel_done ? '0 : rel_diff[ENV_W-1:0];
                state_d = rel_done ? S_IDLE : S_RELEASE;
            end else begin
                case (state_q)
                    S_ATTACK: begin
                        level_d = att_level;
                        state_d = att_full ? S_DECAY : S_ATTACK;
                    end
                    S_DECAY: begin
                        level_d = dec_done ? sustain_level : dec_diff[ENV_W-1:0];
                        state_d = dec_done ? S_SUSTAIN : S_DECAY;
                    end
                    S_SUSTAIN: begin
                        level_d = sustain_level;
                    end
                    default: begin
                        level_d = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            level_q  <= '0;
            sample_q <= '0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            sample_q <= sample_d;
            key_q    <= key_on;
        end
    end

    assign sample_out = sample_q;
    assign env_level  = level_q;
    assign env_state  = state_q;
    assign active     = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios with literal expectations
// plus a randomized run against an integer-arithmetic envelope model.
module tb_adsr_envelope;

    logic        Clk;
    logic        Reset;
    logic        sample_tick;
    logic        key_on;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    int total = 0;
    int bad   = 0;

    // Behavioural model: stage as a small integer, level as a plain int.
    localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;
    int          m_state;
    int          m_level;
    bit          m_key_q;
    logic [15:0] m_out;

    adsr_envelope #(.DATA_W(16), .ENV_W(16)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_tick  (sample_tick),
        .key_on       (key_on),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .env_level    (env_level),
        .env_state    (env_state),
        .active       (active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_state = M_IDLE;
        m_level = 0;
        m_key_q = 1'b0;
        m_out   = 16'h0000;
    endtask

    task automatic model_attack(input int a);
        if (m_level + a >= 65535) begin
            m_level = 65535;
            m_state = M_DECAY;
        end else begin
            m_level = m_level + a;
            m_state = M_ATTACK;
        end
    endtask

    task automatic model_release(input int r);
        if (m_level - r <= 0) begin
            m_level = 0;
            m_state = M_IDLE;
        end else begin
            m_level = m_level - r;
            m_state = M_RELEASE;
        end
    endtask

    // Advance the model by one clock using the inputs the DUT saw at that edge.
    task automatic model_clock();
        longint p;
        longint sh;
        int     a, d, r, s;
        bit     rise;
        a = (attack_rate  == 0) ? 1 : int'(attack_rate);
        d = (decay_rate   == 0) ? 1 : int'(decay_rate);
        r = (release_rate == 0) ? 1 : int'(release_rate);
        s = int'(sustain_level);
        rise = key_on && !m_key_q;
        if (sample_tick) begin
            p  = longint'($signed(sample_in)) * longint'(m_level);
            sh = p >>> 16;
            m_out = sh[15:0];
        end
        if (rise) begin
            m_state = M_ATTACK;
            if (sample_tick) model_attack(a);
        end else if (sample_tick) begin
            if (!key_on && (m_state == M_ATTACK || m_state == M_DECAY || m_state == M_SUSTAIN))
                model_release(r);
            else if (m_state == M_RELEASE)
                model_release(r);
            else if (m_state == M_ATTACK)
                model_attack(a);
            else if (m_state == M_DECAY) begin
                if (m_level - d <= s) begin
                    m_level = s;
                    m_state = M_SUSTAIN;
                end else begin
                    m_level = m_level - d;
                end
            end else if (m_state == M_SUSTAIN)
                m_level = s;
            else
                m_level = 0;
        end
        m_key_q = key_on;
    endtask

    task automatic clk_step(input bit tick);
        sample_tick = tick;
        @(posedge Clk);
        #1;
        model_clock();
        sample_tick = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        key_on = 1'b0;
        sample_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        total++;
        if (env_level !== 16'h0 || env_state !== 3'd0 || active !== 1'b0 || sample_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_initial: level=%h state=%0d active=%b out=%h, want all 0",
                     env_level, env_state, active, sample_out);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        attack_rate = 16'h2000; decay_rate = 16'h1000; sustain_level = 16'h8000; release_rate = 16'h2000;
        sample_in = 16'h4000;
        key_on = 1'b1;
        clk_step(1'b1);
        clk_step(1'b1);
        total++;
        if (env_level !== 16'h4000 || env_state !== 3'd1 || sample_out !== 16'h0800) begin
            bad++;
            $display("FAIL reset_preattack: level=%h state=%0d out=%h, want 4000 1 0800",
                     env_level, env_state, sample_out);
        end
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if (env_level !== 16'h0 || env_state !== 3'd0 || active !== 1'b0 || sample_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_midnote: level=%h state=%0d active=%b out=%h, want all 0",
                     env_level, env_state, active, sample_out);
        end
        key_on = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            clk_step(1'b1);
            total++;
            if (env_state !== 3'd0 || env_level !== 16'h0 || active !== 1'b0) begin
                bad++;
                $display("FAIL reset_stays_idle[%0d]: state=%0d level=%h active=%b, want 0 0 0",
                         i, env_state, env_level, active);
            end
        end
    endtask

    task automatic test_attack_decay_release();
        logic [15:0] exp_lvl [12];
        int          exp_st  [12];
        logic [15:0] rel_lvl [4];
        exp_lvl[0] = 16'h4000; exp_lvl[1] = 16'h8000; exp_lvl[2] = 16'hC000; exp_lvl[3] = 16'hFFFF;
        exp_st[0] = 1; exp_st[1] = 1; exp_st[2] = 1; exp_st[3] = 2;
        for (int k = 0; k < 7; k++) begin
            exp_lvl[4+k] = 16'hEFFF - 16'(k * 16'h1000);
            exp_st[4+k]  = 2;
        end
        exp_lvl[11] = 16'h8000; exp_st[11] = 3;
        rel_lvl[0] = 16'h6000; rel_lvl[1] = 16'h4000; rel_lvl[2] = 16'h2000; rel_lvl[3] = 16'h0000;

        apply_reset();
        attack_rate = 16'h4000; decay_rate = 16'h1000; sustain_level = 16'h8000; release_rate = 16'h2000;
        sample_in = 16'h0000;
        key_on = 1'b1;
        clk_step(1'b0);
        for (int i = 0; i < 12; i++) begin
            repeat (3) clk_step(1'b0);
            clk_step(1'b1);
            total++;
            if (env_level !== exp_lvl[i] || env_state !== 3'(exp_st[i])) begin
                bad++;
                $display("FAIL adsr_step[%0d]: level=%h state=%0d, want %h %0d",
                         i, env_level, env_state, exp_lvl[i], exp_st[i]);
            end
        end
        key_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) clk_step(1'b0);
            clk_step(1'b1);
            total++;
            if (env_level !== rel_lvl[i] || env_state !== ((i == 3) ? 3'd0 : 3'd4) ||
                active !== (i != 3)) begin
                bad++;
                $display("FAIL release_step[%0d]: level=%h state=%0d active=%b, want %h %0d %b",
                         i, env_level, env_state, active, rel_lvl[i], (i == 3) ? 0 : 4, i != 3);
            end
        end
    endtask

    task automatic test_retrigger();
        int n;
        apply_reset();
        attack_rate = 16'h4000; decay_rate = 16'h1000; sustain_level = 16'h8000; release_rate = 16'h1000;
        key_on = 1'b1;
        n = 0;
        clk_step(1'b1);
        while (env_state !== 3'd3 && n < 40) begin
            clk_step(1'b1);
            n++;
        end
        total++;
        if (env_state !== 3'd3) begin
            bad++;
            $display("FAIL retrig_reach_sustain: state=%0d after %0d ticks, want 3", env_state, n);
        end
        key_on = 1'b0;
        repeat (5) clk_step(1'b1);
        total++;
        if (env_level !== 16'h3000 || env_state !== 3'd4) begin
            bad++;
            $display("FAIL retrig_release: level=%h state=%0d, want 3000 4", env_level, env_state);
        end
        key_on = 1'b1;
        clk_step(1'b0);
        total++;
        if (env_level !== 16'h3000 || env_state !== 3'd1) begin
            bad++;
            $display("FAIL retrig_enter: level=%h state=%0d, want 3000 1", env_level, env_state);
        end
        clk_step(1'b1);
        total++;
        if (env_level !== 16'h7000 || env_state !== 3'd1) begin
            bad++;
            $display("FAIL retrig_step: level=%h state=%0d, want 7000 1", env_level, env_state);
        end
    endtask

    task automatic test_scaling();
        apply_reset();
        attack_rate = 16'hFFFF; decay_rate = 16'hFFFF; sustain_level = 16'h8000; release_rate = 16'hFFFF;
        sample_in = 16'h0000;
        key_on = 1'b1;
        clk_step(1'b1);
        sample_in = 16'h7FFF;
        clk_step(1'b1);
        total++;
        if (sample_out !== 16'h7FFE || env_level !== 16'h8000 || env_state !== 3'd3) begin
            bad++;
            $display("FAIL scale_full: out=%h level=%h state=%0d, want 7FFE 8000 3",
                     sample_out, env_level, env_state);
        end
        sample_in = 16'h1234;
        clk_step(1'b0);
        total++;
        if (sample_out !== 16'h7FFE) begin
            bad++;
            $display("FAIL scale_hold: out=%h, want 7FFE", sample_out);
        end
        sample_in = 16'h8000;
        clk_step(1'b1);
        total++;
        if (sample_out !== 16'hC000) begin
            bad++;
            $display("FAIL scale_neg: out=%h, want C000", sample_out);
        end
        key_on = 1'b0;
        sample_in = 16'h7FFF;
        clk_step(1'b1);
        total++;
        if (sample_out !== 16'h3FFF || env_state !== 3'd0) begin
            bad++;
            $display("FAIL scale_half: out=%h state=%0d, want 3FFF 0", sample_out, env_state);
        end
        clk_step(1'b1);
        total++;
        if (sample_out !== 16'h0000) begin
            bad++;
            $display("FAIL scale_zero: out=%h, want 0000", sample_out);
        end
    endtask

    task automatic test_zero_rates();
        apply_reset();
        attack_rate = 16'h0; decay_rate = 16'h0; sustain_level = 16'h0; release_rate = 16'h0;
        key_on = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            clk_step(1'b1);
            total++;
            if (env_level !== 16'(i) || env_state !== 3'd1) begin
                bad++;
                $display("FAIL zero_attack[%0d]: level=%h state=%0d, want %h 1", i, env_level, env_state, i);
            end
        end
        key_on = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            clk_step(1'b1);
            total++;
            if (env_level !== 16'(i) || env_state !== ((i == 0) ? 3'd0 : 3'd4)) begin
                bad++;
                $display("FAIL zero_release[%0d]: level=%h state=%0d, want %h %0d",
                         i, env_level, env_state, i, (i == 0) ? 0 : 4);
            end
        end
        attack_rate = 16'h1234;
        key_on = 1'b1;
        clk_step(1'b1);
        total++;
        if (env_level !== 16'h1234 || env_state !== 3'd1) begin
            bad++;
            $display("FAIL rise_with_tick: level=%h state=%0d, want 1234 1", env_level, env_state);
        end
        attack_rate = 16'hFFFF;
        clk_step(1'b1);
        sustain_level = 16'hFFFF;
        clk_step(1'b1);
        total++;
        if (env_level !== 16'hFFFF || env_state !== 3'd3) begin
            bad++;
            $display("FAIL sustain_at_max: level=%h state=%0d, want FFFF 3", env_level, env_state);
        end
        sustain_level = 16'h0000;
        key_on = 1'b0;
        clk_step(1'b0);
        key_on = 1'b1;
        clk_step(1'b1);
        clk_step(1'b1);
        total++;
        if (env_level !== 16'hFFFE || env_state !== 3'd2) begin
            bad++;
            $display("FAIL zero_decay: level=%h state=%0d, want FFFE 2", env_level, env_state);
        end
    endtask

    function automatic logic [15:0] rand_rate();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 16));
            2:       return 16'($urandom_range(16'h0100, 16'h2000));
            default: return 16'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    task automatic test_random();
        bit tick;
        apply_reset();
        attack_rate = rand_rate(); decay_rate = rand_rate();
        release_rate = rand_rate(); sustain_level = 16'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                attack_rate = rand_rate(); decay_rate = rand_rate(); release_rate = rand_rate();
            end
            if ($urandom_range(0, 29) == 0) sustain_level = 16'($urandom);
            if ($urandom_range(0, 39) == 0) key_on = ~key_on;
            sample_in = 16'($urandom);
            tick = ($urandom_range(0, 2) == 0);
            clk_step(tick);
            total++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) ||
                active !== (m_state != M_IDLE) || sample_out !== m_out) begin
                bad++;
                $display("FAIL random[%0d]: level=%h state=%0d active=%b out=%h, want %h %0d %b %h",
                         i, env_level, env_state, active, sample_out,
                         16'(m_level), m_state, m_state != M_IDLE, m_out);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        sample_tick = 1'b0;
        key_on = 1'b0;
        attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
        sample_in = '0;
        model_reset();
        test_reset();
        test_attack_decay_release();
        test_retrigger();
        test_scaling();
        test_zero_rates();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
